// File: rtl/cnn_layer_accel_sysmem_pkg.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_sysmem_pkg
// Shared types and constants for the system-memory read engine that feeds
// cnn_layer_accel_FAS: controller state encoding, destination buffer indices
// and the default number of destination buffers.
// ---------------------------------------------------------------------------
package cnn_layer_accel_sysmem_pkg;

  localparam int C_NUM_DEST_DEFAULT = 7;
  localparam int DEST_SEL_WIDTH     = 3;

  // Destination buffer indices, as presented on rd_dest_sel.
  localparam logic [DEST_SEL_WIDTH-1:0] DEST_TRANS        = 3'd0;
  localparam logic [DEST_SEL_WIDTH-1:0] DEST_CONV_MAP     = 3'd1;
  localparam logic [DEST_SEL_WIDTH-1:0] DEST_RESD_MAP     = 3'd2;
  localparam logic [DEST_SEL_WIDTH-1:0] DEST_PART_MAP     = 3'd3;
  localparam logic [DEST_SEL_WIDTH-1:0] DEST_PREV_MAP     = 3'd4;
  localparam logic [DEST_SEL_WIDTH-1:0] DEST_KRNL1X1      = 3'd5;
  localparam logic [DEST_SEL_WIDTH-1:0] DEST_KRNL1X1_BIAS = 3'd6;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    CMD,
    XFER,
    CMPL
  } rd_state_e;

endpackage

// File: rtl/cnn_layer_accel_rd_dest_demux.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_rd_dest_demux
// Registers an accepted read beat and steers it to one FAS input buffer.
// The write enable is one-hot on the selected destination and appears exactly
// one cycle after the beat is accepted; an out-of-range destination produces
// no write enable at all.
//
// Ports:
//   clk_core     in   core clock
//   rst          in   synchronous active-high reset
//   beat_accept  in   beat accepted this cycle (valid & ready)
//   beat_dest    in   latched destination index
//   beat_data    in   accepted beat data
//   dest_wren    out  registered one-hot write enable per destination
//   dest_datain  out  registered beat data shared by all destinations
// ---------------------------------------------------------------------------
module cnn_layer_accel_rd_dest_demux
  import cnn_layer_accel_sysmem_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128,
  parameter int C_NUM_DEST   = C_NUM_DEST_DEFAULT
) (
  input  logic                      clk_core,
  input  logic                      rst,
  input  logic                      beat_accept,
  input  logic [DEST_SEL_WIDTH-1:0] beat_dest,
  input  logic [C_DATA_WIDTH-1:0]   beat_data,
  output logic [C_NUM_DEST-1:0]     dest_wren,
  output logic [C_DATA_WIDTH-1:0]   dest_datain
);

  logic [C_NUM_DEST-1:0]   wren_d,   wren_q;
  logic [C_DATA_WIDTH-1:0] datain_d, datain_q;

  always_comb begin
    wren_d   = '0;
    datain_d = datain_q;
    if (beat_accept) begin
      datain_d = beat_data;
      for (int i = 0; i < C_NUM_DEST; i++) begin
        if (int'(beat_dest) == i) wren_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      wren_q   <= '0;
      // NOTE: datain is only a data register, but it drives a port that must
      // read zero out of reset, so it is cleared along with the control flops.
      datain_q <= '0;
    end else begin
      wren_q   <= wren_d;
      datain_q <= datain_d;
    end
  end

  assign dest_wren   = wren_q;
  assign dest_datain = datain_q;

endmodule

// File: rtl/cnn_layer_accel_sysmem_rd_ctrl.sv
// ---------------------------------------------------------------------------
// cnn_layer_accel_sysmem_rd_ctrl
// System-memory read engine upstream of cnn_layer_accel_FAS. Serves one FAS
// read request at a time: acknowledges and latches the descriptor, issues a
// single burst command, accepts the returned beats subject to per-destination
// backpressure and forwards them to one FAS input buffer.
//
// Optional feature (macro SYSMEM_RD_PERF_CNT_EN): adds perf_beats,
// perf_stall_cyc and perf_bursts counters; core behaviour is unchanged.
//
// Ports:
//   clk_core, rst                    clock, synchronous active-high reset
//   sys_mem_read_req/_ack/_in_prog/_cmpl  FAS read handshake
//   rd_addr, rd_len, rd_dest_sel     request descriptor, sampled with ack
//   mem_cmd_valid/ready/addr/len     burst command to the memory port
//   mem_rd_valid/ready/data          read beat stream from the memory port
//   dest_stall                       per-destination backpressure
//   dest_wren, dest_datain           one-hot write enable and beat data
//   err_bad_dest                     sticky invalid-destination flag
// ---------------------------------------------------------------------------
module cnn_layer_accel_sysmem_rd_ctrl
  import cnn_layer_accel_sysmem_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 32,
  parameter int C_DATA_WIDTH = 128,
  parameter int C_LEN_WIDTH  = 16,
  parameter int C_NUM_DEST   = C_NUM_DEST_DEFAULT
) (
  input  logic                      clk_core,
  input  logic                      rst,
  input  logic                      sys_mem_read_req,
  output logic                      sys_mem_read_req_ack,
  output logic                      sys_mem_read_in_prog,
  output logic                      sys_mem_read_cmpl,
  input  logic [C_ADDR_WIDTH-1:0]   rd_addr,
  input  logic [C_LEN_WIDTH-1:0]    rd_len,
  input  logic [DEST_SEL_WIDTH-1:0] rd_dest_sel,
  output logic                      mem_cmd_valid,
  input  logic                      mem_cmd_ready,
  output logic [C_ADDR_WIDTH-1:0]   mem_cmd_addr,
  output logic [C_LEN_WIDTH-1:0]    mem_cmd_len,
  input  logic                      mem_rd_valid,
  output logic                      mem_rd_ready,
  input  logic [C_DATA_WIDTH-1:0]   mem_rd_data,
  input  logic [C_NUM_DEST-1:0]     dest_stall,
  output logic [C_NUM_DEST-1:0]     dest_wren,
  output logic [C_DATA_WIDTH-1:0]   dest_datain,
  output logic                      err_bad_dest
`ifdef SYSMEM_RD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_beats,
  output logic [31:0]               perf_stall_cyc,
  output logic [15:0]               perf_bursts
`endif
);

  rd_state_e                 state_d, state_q;
  logic [C_ADDR_WIDTH-1:0]   addr_d,  addr_q;
  logic [C_LEN_WIDTH-1:0]    len_d,   len_q;
  logic [C_LEN_WIDTH-1:0]    cnt_d,   cnt_q;
  logic [DEST_SEL_WIDTH-1:0] dest_d,  dest_q;
  logic                      err_d,   err_q;
  logic                      dest_ok;
  logic                      beat_accept;

  always_comb begin
    // NOTE: every output and next-state value gets a default before the case
    // so that no path through the block leaves a latch behind.
    state_d              = state_q;
    addr_d               = addr_q;
    len_d                = len_q;
    cnt_d                = cnt_q;
    dest_d               = dest_q;
    err_d                = err_q;
    sys_mem_read_req_ack = 1'b0;
    sys_mem_read_in_prog = 1'b0;
    sys_mem_read_cmpl    = 1'b0;
    mem_cmd_valid        = 1'b0;
    mem_rd_ready         = 1'b0;
    beat_accept          = 1'b0;
    dest_ok              = int'(dest_q) < C_NUM_DEST;

    unique case (state_q)
      IDLE: begin
        if (sys_mem_read_req) state_d = ACK;
      end
      ACK: begin
        sys_mem_read_req_ack = 1'b1;
        addr_d = rd_addr;
        len_d  = rd_len;
        dest_d = rd_dest_sel;
        cnt_d  = '0;
        if (int'(rd_dest_sel) >= C_NUM_DEST) err_d = 1'b1;
        state_d = (rd_len == '0) ? CMPL : CMD;
      end
      CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_d = XFER;
      end
      XFER: begin
        sys_mem_read_in_prog = 1'b1;
        // Beats for an invalid destination are drained so the memory port
        // never hangs; the demux simply produces no write for them.
        mem_rd_ready = dest_ok ? ~dest_stall[dest_q] : 1'b1;
        beat_accept  = mem_rd_valid & mem_rd_ready;
        if (beat_accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) state_d = CMPL;
        end
      end
      CMPL: begin
        sys_mem_read_cmpl = 1'b1;
        if (!sys_mem_read_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      dest_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      dest_q  <= dest_d;
      err_q   <= err_d;
    end
  end

  assign mem_cmd_addr = addr_q;
  assign mem_cmd_len  = len_q;
  assign err_bad_dest = err_q;

  cnn_layer_accel_rd_dest_demux #(
    .C_DATA_WIDTH (C_DATA_WIDTH),
    .C_NUM_DEST   (C_NUM_DEST)
  ) u_dest_demux (
    .clk_core    (clk_core),
    .rst         (rst),
    .beat_accept (beat_accept),
    .beat_dest   (dest_q),
    .beat_data   (mem_rd_data),
    .dest_wren   (dest_wren),
    .dest_datain (dest_datain)
  );

`ifdef SYSMEM_RD_PERF_CNT_EN
  logic [31:0] perf_beats_d, perf_beats_q;
  logic [31:0] perf_stall_cyc_d, perf_stall_cyc_q;
  logic [15:0] perf_bursts_d, perf_bursts_q;

  // All counters wrap naturally at full scale.
  always_comb begin
    perf_beats_d     = perf_beats_q + 32'(beat_accept);
    perf_stall_cyc_d = perf_stall_cyc_q
                     + 32'(sys_mem_read_in_prog & mem_rd_valid & ~mem_rd_ready);
    perf_bursts_d    = perf_bursts_q + 16'(mem_cmd_valid & mem_cmd_ready);
  end

  always_ff @(posedge clk_core) begin
    if (rst) begin
      perf_beats_q     <= '0;
      perf_stall_cyc_q <= '0;
      perf_bursts_q    <= '0;
    end else begin
      perf_beats_q     <= perf_beats_d;
      perf_stall_cyc_q <= perf_stall_cyc_d;
      perf_bursts_q    <= perf_bursts_d;
    end
  end

  assign perf_beats     = perf_beats_q;
  assign perf_stall_cyc = perf_stall_cyc_q;
  assign perf_bursts    = perf_bursts_q;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_sysmem_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cnn_layer_accel_sysmem_rd_ctrl
// Self-checking bench for cnn_layer_accel_sysmem_rd_ctrl. A negedge monitor
// tracks the protocol (burst started by the command handshake, ended after
// len accepted beats) and checks ready, in_prog, command hold and the
// one-cycle write-enable/data forwarding. Transactions come from a vector
// table, a few hand-written sequences and a randomized run.
// ---------------------------------------------------------------------------
module tb_cnn_layer_accel_sysmem_rd_ctrl;

  logic         clk_core = 1'b0;
  logic         rst = 1'b1;
  logic         sys_mem_read_req = 1'b0;
  logic         sys_mem_read_req_ack, sys_mem_read_in_prog, sys_mem_read_cmpl;
  logic [31:0]  rd_addr = '0;
  logic [15:0]  rd_len = '0;
  logic [2:0]   rd_dest_sel = '0;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready = 1'b0;
  logic [31:0]  mem_cmd_addr;
  logic [15:0]  mem_cmd_len;
  logic         mem_rd_valid = 1'b0;
  logic         mem_rd_ready;
  logic [127:0] mem_rd_data = '0;
  logic [6:0]   dest_stall = '0;
  logic [6:0]   dest_wren;
  logic [127:0] dest_datain;
  logic         err_bad_dest;
`ifdef SYSMEM_RD_PERF_CNT_EN
  logic [31:0]  perf_beats, perf_stall_cyc;
  logic [15:0]  perf_bursts;
`endif

  always #5 clk_core = ~clk_core;

  cnn_layer_accel_sysmem_rd_ctrl dut (
    .clk_core             (clk_core),
    .rst                  (rst),
    .sys_mem_read_req     (sys_mem_read_req),
    .sys_mem_read_req_ack (sys_mem_read_req_ack),
    .sys_mem_read_in_prog (sys_mem_read_in_prog),
    .sys_mem_read_cmpl    (sys_mem_read_cmpl),
    .rd_addr              (rd_addr),
    .rd_len               (rd_len),
    .rd_dest_sel          (rd_dest_sel),
    .mem_cmd_valid        (mem_cmd_valid),
    .mem_cmd_ready        (mem_cmd_ready),
    .mem_cmd_addr         (mem_cmd_addr),
    .mem_cmd_len          (mem_cmd_len),
    .mem_rd_valid         (mem_rd_valid),
    .mem_rd_ready         (mem_rd_ready),
    .mem_rd_data          (mem_rd_data),
    .dest_stall           (dest_stall),
    .dest_wren            (dest_wren),
    .dest_datain          (dest_datain),
    .err_bad_dest         (err_bad_dest)
`ifdef SYSMEM_RD_PERF_CNT_EN
    ,
    .perf_beats           (perf_beats),
    .perf_stall_cyc       (perf_stall_cyc),
    .perf_bursts          (perf_bursts)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] ctrl_vec();
    return {67'd0, sys_mem_read_req_ack, sys_mem_read_in_prog, sys_mem_read_cmpl,
            mem_cmd_valid, mem_cmd_addr, mem_cmd_len, mem_rd_ready, dest_wren, err_bad_dest};
  endfunction

  // ---------------- protocol monitor / reference model ----------------
  bit           mon_en = 1'b0;
  logic         prev_acc, prev_cmd_wait, in_xfer, exp_rdy, stall_bit;
  logic [2:0]   prev_dest;
  logic [127:0] prev_data;
  logic [6:0]   exp_wren;
  int           beats_left;

  always @(negedge clk_core) begin
    if (!mon_en) begin
      prev_acc = 1'b0; prev_cmd_wait = 1'b0; in_xfer = 1'b0; beats_left = 0;
    end else begin
      exp_wren = (prev_acc && prev_dest != 3'd7) ? (7'd1 << prev_dest) : 7'd0;
      check("wren", dest_wren, exp_wren);
      if (exp_wren != 7'd0) check("datain", dest_datain, prev_data);
      stall_bit = (rd_dest_sel != 3'd7) ? dest_stall[rd_dest_sel] : 1'b0;
      exp_rdy = in_xfer && !stall_bit;
      check("rd_ready", mem_rd_ready, exp_rdy);
      check("in_prog", sys_mem_read_in_prog, in_xfer);
      if (prev_cmd_wait) check("cmd_hold", mem_cmd_valid, 1);
      prev_cmd_wait = mem_cmd_valid && !mem_cmd_ready;
      prev_acc  = mem_rd_valid && mem_rd_ready;
      prev_dest = rd_dest_sel;
      prev_data = mem_rd_data;
      if (prev_acc && in_xfer) begin
        beats_left--;
        if (beats_left == 0) in_xfer = 1'b0;
      end
      if (mem_cmd_valid && mem_cmd_ready) begin
        check("cmd_addr", mem_cmd_addr, rd_addr);
        check("cmd_len", mem_cmd_len, rd_len);
        in_xfer = 1'b1;
        beats_left = int'(rd_len);
      end
    end
  end

  // ---------------- transaction driver ----------------
  task automatic run_txn(input logic [31:0] a, input logic [15:0] l, input logic [2:0] d,
                         input int slo, input int shi, input bit rnd,
                         output int n_ack, output int n_cmd, output int n_wr,
                         output int n_blk, output int a2c);
    int xcyc, a_cyc, hold;
    bit done;
    logic [127:0] beat;
    n_ack = 0; n_cmd = 0; n_wr = 0; n_blk = 0; a2c = -1;
    xcyc = 0; a_cyc = -1; done = 1'b0;
    beat = {$urandom, $urandom, $urandom, $urandom};
    rd_addr = a; rd_len = l; rd_dest_sel = d; sys_mem_read_req = 1'b1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      mem_cmd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      mem_rd_valid  = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      mem_rd_data   = beat;
      if (rnd) dest_stall = 7'($urandom_range(0, 127)) & {7{$urandom_range(0, 2) == 0}};
      else dest_stall = (xcyc + 1 >= slo && xcyc + 1 <= shi && d != 3'd7) ? (7'd1 << d) : 7'd0;
      @(negedge clk_core);
      if (sys_mem_read_req_ack) begin n_ack++; a_cyc = cyc; end
      if (mem_cmd_valid && mem_cmd_ready) n_cmd++;
      if (dest_wren != 7'd0) n_wr++;
      if (sys_mem_read_in_prog) begin
        xcyc++;
        if (mem_rd_valid && !mem_rd_ready) n_blk++;
      end
      if (mem_rd_valid && mem_rd_ready) beat = {$urandom, $urandom, $urandom, $urandom};
      if (sys_mem_read_cmpl) begin done = 1'b1; a2c = cyc - a_cyc; end
      @(posedge clk_core); #1;
    end
    check("cmpl_reached", done, 1);
    hold = rnd ? $urandom_range(0, 3) : 1;
    dest_stall = '0; mem_rd_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk_core);
      check("cmpl_hold", sys_mem_read_cmpl, 1);
      @(posedge clk_core); #1;
    end
    sys_mem_read_req = 1'b0;
    @(negedge clk_core);
    check("cmpl_drop_cycle", sys_mem_read_cmpl, 1);
    @(posedge clk_core); #1;
  endtask

  typedef struct {
    logic [31:0] addr; logic [15:0] len; logic [2:0] dest;
    int slo; int shi;
    int exp_cmd; int exp_wr; int exp_blk; int exp_a2c; logic exp_err;
  } vec_t;

  vec_t vecs[5];
  int n_ack, n_cmd, n_wr, n_blk, a2c, acc;
  bit saw_bad;
  logic [15:0] rl;
  logic [2:0]  rdst;

  initial begin
    //          addr      len    dest  stall   cmd wr blk a2c err
    vecs[0] = '{32'h1000, 16'd4, 3'd1, 0, -1,  1,  4, 0,  6,  1'b0};
    vecs[1] = '{32'h2000, 16'd8, 3'd0, 3,  6,  1,  8, 4,  14, 1'b0};
    vecs[2] = '{32'h3000, 16'd0, 3'd5, 0, -1,  0,  0, 0,  1,  1'b0};
    vecs[3] = '{32'h4000, 16'd3, 3'd7, 0, -1,  1,  0, 0,  5,  1'b1};
    vecs[4] = '{32'h5000, 16'd2, 3'd6, 0, -1,  1,  2, 0,  4,  1'b1};

    // Reset state.
    repeat (3) @(posedge clk_core);
    #1 rst = 1'b0;
    @(negedge clk_core);
    check("reset_ctrl", ctrl_vec(), '0);
    check("reset_datain", dest_datain, '0);
    @(posedge clk_core); #1;
    mon_en = 1'b1;

    // Directed table.
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i].addr, vecs[i].len, vecs[i].dest, vecs[i].slo, vecs[i].shi, 1'b0,
              n_ack, n_cmd, n_wr, n_blk, a2c);
      check($sformatf("v%0d_ack", i), n_ack, 1);
      check($sformatf("v%0d_cmd", i), n_cmd, vecs[i].exp_cmd);
      check($sformatf("v%0d_wren_cnt", i), n_wr, vecs[i].exp_wr);
      check($sformatf("v%0d_blocked", i), n_blk, vecs[i].exp_blk);
      check($sformatf("v%0d_ack2cmpl", i), a2c, vecs[i].exp_a2c);
      check($sformatf("v%0d_err", i), err_bad_dest, vecs[i].exp_err);
    end

    // Reset in the middle of a 16-beat burst, after the fifth accepted beat.
    rd_addr = 32'h6000; rd_len = 16'd16; rd_dest_sel = 3'd2; sys_mem_read_req = 1'b1;
    mem_cmd_ready = 1'b1; mem_rd_valid = 1'b1; dest_stall = '0;
    acc = 0;
    for (int c = 0; c < 100 && acc < 5; c++) begin
      mem_rd_data = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk_core);
      if (mem_rd_valid && mem_rd_ready) acc++;
      @(posedge clk_core); #1;
    end
    check("mid_beats_seen", acc, 5);
    mon_en = 1'b0; rst = 1'b1; sys_mem_read_req = 1'b0;
    @(posedge clk_core); #1;
    @(negedge clk_core);
    check("mid_rst_ctrl", ctrl_vec(), '0);
    check("mid_rst_datain", dest_datain, '0);
    rst = 1'b0;
    @(posedge clk_core); #1;
    @(negedge clk_core);
    check("post_rst_ctrl", ctrl_vec(), '0);
    @(posedge clk_core); #1;
    mon_en = 1'b1;
    run_txn(32'h7000, 16'd5, 3'd3, 0, -1, 1'b0, n_ack, n_cmd, n_wr, n_blk, a2c);
    check("fresh_ack", n_ack, 1);
    check("fresh_wren_cnt", n_wr, 5);
    check("fresh_err", err_bad_dest, 0);

    // Back-to-back: run_txn returns in the cycle after req dropped.
    run_txn(32'h8000, 16'd3, 3'd4, 0, -1, 1'b0, n_ack, n_cmd, n_wr, n_blk, a2c);
    check("b2b_first_wren_cnt", n_wr, 3);
    rd_addr = 32'h9000; rd_len = 16'd0; rd_dest_sel = 3'd5; sys_mem_read_req = 1'b1;
    @(negedge clk_core);
    check("b2b_cmpl_clear", sys_mem_read_cmpl, 0);
    check("b2b_no_early_ack", sys_mem_read_req_ack, 0);
    @(posedge clk_core); #1;
    @(negedge clk_core);
    check("b2b_ack", sys_mem_read_req_ack, 1);
    @(posedge clk_core); #1;
    @(negedge clk_core);
    check("b2b_ack_pulse", sys_mem_read_req_ack, 0);
    check("b2b_zero_len_cmpl", sys_mem_read_cmpl, 1);
    @(posedge clk_core); #1;
    sys_mem_read_req = 1'b0;
    @(posedge clk_core); #1;

    // Randomized transactions against the model.
    saw_bad = 1'b0;
    for (int t = 0; t < 25; t++) begin
      rl   = 16'($urandom_range(0, 12));
      rdst = 3'($urandom_range(0, 7));
      if (rdst == 3'd7) saw_bad = 1'b1;
      run_txn($urandom, rl, rdst, 0, -1, 1'b1, n_ack, n_cmd, n_wr, n_blk, a2c);
      check($sformatf("r%0d_ack", t), n_ack, 1);
      check($sformatf("r%0d_cmd", t), n_cmd, (rl != 0) ? 1 : 0);
      check($sformatf("r%0d_wren_cnt", t), n_wr, (rdst != 3'd7) ? int'(rl) : 0);
    end
    check("rand_err", err_bad_dest, saw_bad);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_sysmem_rd_ctrl.md
Name: cnn_layer_accel_sysmem_rd_ctrl

Overview:
System-memory read engine directly upstream of cnn_layer_accel_FAS. It serves the FAS read handshake (sys_mem_read_req/ack/in_prog/cmpl) and issues one burst command to the memory port. Returned beats are routed to exactly one FAS input buffer (trans FIFO, conv/resd/part map BRAMs, prev map FIFO, 1x1 kernel/bias BRAMs) through a per-destination write-enable and shared datain. One request is in flight at a time.

Parameters:
C_ADDR_WIDTH, 32, byte address width of memory port
C_DATA_WIDTH, 128, beat width (memory data and dest_datain)
C_LEN_WIDTH, 16, burst length field width, in beats
C_NUM_DEST, 7, number of FAS input buffers

Ports:
clk_core  in  1  core clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
sys_mem_read_req  in  1  FAS read request; level, held until cmpl seen
sys_mem_read_req_ack  out  1  one-cycle pulse: descriptor latched
sys_mem_read_in_prog  out  1  high while beats are transferring
sys_mem_read_cmpl  out  1  high from last beat written until req drops
rd_addr  in  C_ADDR_WIDTH  burst start address, sampled with ack
rd_len  in  C_LEN_WIDTH  beats to fetch, sampled with ack
rd_dest_sel  in  3  0 trans,1 convMap,2 resdMap,3 partMap,4 prevMap,5 krnl1x1,6 krnl1x1Bias
mem_cmd_valid  out  1  burst command valid
mem_cmd_ready  in  1  memory accepts command
mem_cmd_addr  out  C_ADDR_WIDTH  latched rd_addr
mem_cmd_len  out  C_LEN_WIDTH  latched rd_len
mem_rd_valid  in  1  read beat valid
mem_rd_ready  out  1  engine accepts beat
mem_rd_data  in  C_DATA_WIDTH  read beat
dest_stall  in  C_NUM_DEST  per-destination almost-full/backpressure
dest_wren  out  C_NUM_DEST  one-hot write enable, bit = rd_dest_sel
dest_datain  out  C_DATA_WIDTH  registered beat data
err_bad_dest  out  1  sticky: rd_dest_sel >= C_NUM_DEST seen

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, err_bad_dest cleared. Reset mid-transfer abandons the burst; no further wren.
- FSM IDLE -> ACK when sys_mem_read_req=1 and cmpl=0.
- ACK (1 cycle): req_ack=1; latch addr/len/dest. If len=0 -> CMPL, else -> CMD.
- CMD: mem_cmd_valid=1 with latched addr/len. On mem_cmd_ready -> XFER. Valid is never withdrawn before ready.
- XFER: in_prog=1. mem_rd_ready = ~dest_stall[dest] (=1 when dest invalid). A beat is accepted when valid&ready.
- Accepted beat: next cycle dest_wren[dest]=1 and dest_datain=beat. Latency is exactly 1 cycle; at most one wren bit is ever set.
- Beat counter increments per accept. The accept with count=len-1 -> CMPL.
- Beats arriving in CMPL/IDLE are not accepted (mem_rd_ready=0).
- CMPL: in_prog=0, cmpl=1, held until sys_mem_read_req=0, then -> IDLE. The cycle after req drops, cmpl=0. A new req asserted in that same cycle is not acked until IDLE is re-entered.
- Invalid dest: beats are consumed and counted, no wren; err_bad_dest=1 until rst.
- dest_stall changing mid-burst takes effect on mem_rd_ready the same cycle (combinational). The registered beat still writes.

Optional Feature:
Macro SYSMEM_RD_PERF_CNT_EN. With it defined, three extra outputs are present: perf_beats (32b, total accepted beats), perf_stall_cyc (32b, XFER cycles with mem_rd_valid=1 and ready=0) and perf_bursts (16b). All are cleared by rst and wrap at full scale. Without it these ports and counters do not exist, and the core behaviour is identical.

Decomposition:
Package cnn_layer_accel_sysmem_pkg holds:
- state enum (IDLE, ACK, CMD, XFER, CMPL)
- destination index localparams (DEST_TRANS..DEST_KRNL1X1_BIAS)
- C_NUM_DEST default

Sub-module cnn_layer_accel_rd_dest_demux holds the one-hot decode plus registered wren/datain stage. It is instantiated once.

Test Plan:
- Basic: req, addr=0x1000, len=4, dest=1, mem always ready -> ack pulse, one cmd (0x1000, 4), 4 beats, dest_wren=7'b0000010 for 4 cycles each 1 cycle after accept, then cmpl until req drops.
- Backpressure: len=8, dest=0, dest_stall[0]=1 for cycles 3-6 of XFER -> mem_rd_ready=0 in those cycles, exactly 8 wren total, data order preserved.
- Zero length: len=0, dest=5 -> ack then cmpl next cycle, mem_cmd_valid never asserted, no wren.
- Invalid dest: dest=7, len=3 -> 3 beats consumed, dest_wren stays 0, err_bad_dest=1 and remains after the next good transfer.
- Reset mid-burst: len=16, rst after beat 5 -> all outputs 0 next cycle. A fresh req then completes normally.
- Back-to-back: req reasserted the cycle after cmpl falls -> second ack no earlier than 2 cycles after the first req dropped.
